// File: rtl/duty_button_ctrl.sv
// duty_button_ctrl: synchronizes, debounces and arbitrates the duty-adjust buttons into stretched pulses.
// Define BUTTON_AUTOREPEAT_EN to add auto-repeat while a button stays held.
module duty_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int PULSE_CYCLES    = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic incr_duty,
    output logic decr_duty
);
    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_B = (REPEAT_PERIOD > PULSE_CYCLES) ? REPEAT_PERIOD : PULSE_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] DB_LAST  = TW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES);
`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [TW-1:0] DELAY_LD  = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] PERIOD_LD = TW'(REPEAT_PERIOD);
`endif

    localparam bit PARAMS_OK = (PULSE_CYCLES >= 2) && (REPEAT_PERIOD >= 2 * PULSE_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HOLD    = 2'd1,
`ifdef BUTTON_AUTOREPEAT_EN
        S_REPEAT  = 2'd2,
`endif
        S_LOCKOUT = 2'd3
    } state_t;

    // Bit 0 carries the up button, bit 1 the down button.
    logic [1:0]          sync1_q;
    logic [1:0]          sync2_q;
    logic [1:0]          db_q;
    logic [1:0]          db_prev_q;
    logic [1:0][TW-1:0]  db_cnt_q;

    state_t              state_q, state_d;
    logic                dir_q, dir_d;          // 1 = up, 0 = down
`ifdef BUTTON_AUTOREPEAT_EN
    logic [TW-1:0]       timer_q, timer_d;
`endif
    logic                fire;
    logic                fire_up;
    logic [TW-1:0]       pcnt_q;
    logic                pdir_q;
    logic                incr_q, decr_q;

    logic                db_up, db_dn, up_rise, dn_rise, active, opposite;
    logic                params_ok;

    assign params_ok = PARAMS_OK;

    always_comb begin : param_check
        assert (params_ok)
            else $error("duty_button_ctrl: PULSE_CYCLES must be >= 2 and REPEAT_PERIOD >= 2*PULSE_CYCLES");
    end

    // Synchronizer and symmetric debouncer: a level flips only after a full run of disagreeing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            db_cnt_q  <= '0;
        end else begin
            sync1_q   <= {btn_down, btn_up};
            sync2_q   <= sync1_q;
            db_prev_q <= db_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    db_q[i]     <= ~db_q[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign db_up    = db_q[0];
    assign db_dn    = db_q[1];
    assign up_rise  = db_q[0] & ~db_prev_q[0];
    assign dn_rise  = db_q[1] & ~db_prev_q[1];
    assign active   = dir_q ? db_up : db_dn;
    assign opposite = dir_q ? db_dn : db_up;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
`ifdef BUTTON_AUTOREPEAT_EN
            timer_q <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        fire    = 1'b0;
        fire_up = dir_q;
`ifdef BUTTON_AUTOREPEAT_EN
        timer_d = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (db_up && db_dn) begin
                    state_d = S_LOCKOUT;
                end else if (up_rise || dn_rise) begin
                    fire    = 1'b1;
                    fire_up = up_rise;
                    dir_d   = up_rise;
                    state_d = S_HOLD;
`ifdef BUTTON_AUTOREPEAT_EN
                    timer_d = DELAY_LD;
`endif
                end
            end
`ifdef BUTTON_AUTOREPEAT_EN
            S_HOLD, S_REPEAT: begin
                // Release wins over a lockout, which wins over a due repeat.
                if (!active) begin
                    state_d = S_IDLE;
                end else if (opposite) begin
                    state_d = S_LOCKOUT;
                end else if (timer_q == TW'(1)) begin
                    fire    = 1'b1;
                    fire_up = dir_q;
                    timer_d = PERIOD_LD;
                    state_d = S_REPEAT;
                end
            end
`else
            S_HOLD: begin
                if (!active) begin
                    state_d = S_IDLE;
                end else if (opposite) begin
                    state_d = S_LOCKOUT;
                end
            end
`endif
            S_LOCKOUT: begin
                if (!db_up && !db_dn) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pulse stretcher: one shared counter and direction bit keep the two outputs mutually exclusive.
    always_ff @(posedge clock) begin
        if (reset) begin
            pcnt_q <= '0;
            pdir_q <= 1'b0;
            incr_q <= 1'b0;
            decr_q <= 1'b0;
        end else begin
            if (fire) begin
                pcnt_q <= PULSE_LD;
                pdir_q <= fire_up;
            end else if (pcnt_q != '0) begin
                pcnt_q <= pcnt_q - 1'b1;
            end
            incr_q <= (pcnt_q != '0) &&  pdir_q;
            decr_q <= (pcnt_q != '0) && !pdir_q;
        end
    end

    assign incr_duty = incr_q;
    assign decr_duty = decr_q;

endmodule

// File: tb/tb_duty_button_ctrl.sv
// tb_duty_button_ctrl: directed and randomized button waveforms, expected pulses queued per segment
// and popped by an output monitor that checks direction, rise edge, width and exclusivity.
`timescale 1ns/1ps
module tb_duty_button_ctrl;
    localparam int DB   = 16;
    localparam int RD   = 64;
    localparam int RP   = 16;
    localparam int PC   = 4;
    localparam int MAXL = 1024;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic incr_duty, decr_duty;
    logic [31:0] edge_cnt = 32'd0;

    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 32'd1;

    duty_button_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .PULSE_CYCLES   (PC)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .incr_duty(incr_duty),
        .decr_duty(decr_duty)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_q[$];      // {dir_is_up, absolute rise edge}
    int dexp_rel[$];
    bit dexp_up[$];
    bit raw_up[MAXL];
    bit raw_dn[MAXL];
    bit db_up_m[MAXL];
    bit db_dn_m[MAXL];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, expv, edge_cnt);
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic void clear_raw(input int len);
        for (int k = 0; k < len; k++) begin
            raw_up[k] = 1'b0;
            raw_dn[k] = 1'b0;
        end
    endfunction

    function automatic void set_raw(input bit is_up, input int idx, input bit v);
        if (is_up) raw_up[idx] = v;
        else       raw_dn[idx] = v;
    endfunction

    function automatic void set_range(input bit is_up, input int from, input int to_incl);
        for (int k = from; k <= to_incl; k++) set_raw(is_up, k, 1'b1);
    endfunction

    function automatic void push_dexp(input bit up, input int rel);
        dexp_up.push_back(up);
        dexp_rel.push_back(rel);
    endfunction

    function automatic bit raw_at(input bit is_up, input int idx);
        if (idx < 0) return 1'b0;
        return is_up ? raw_up[idx] : raw_dn[idx];
    endfunction

    // ---------------- reference model ----------------
    // The value sampled by the debouncer at edge j is the raw level driven for edge j-2; a level
    // flips at edge j when the last DB samples all disagree with it. Arbitration then runs on the
    // debounced levels seen before each edge, scheduling repeats by absolute edge number.
    task automatic model_push(input int len, input logic [31:0] base);
        bit prev_level, all_diff, cu, cd, pu, pd, dir, act, opp;
        int mode;
        int next_fire;
        for (int j = 0; j < len; j++) begin
            for (int b = 0; b < 2; b++) begin
                prev_level = 1'b0;
                if (j > 0) prev_level = (b == 0) ? db_up_m[j-1] : db_dn_m[j-1];
                all_diff = 1'b1;
                for (int i = 1; i <= DB; i++)
                    if (raw_at(b == 0, j - 1 - i) == prev_level) all_diff = 1'b0;
                if (b == 0) db_up_m[j] = prev_level ^ all_diff;
                else        db_dn_m[j] = prev_level ^ all_diff;
            end
        end
        mode = 0;
        dir = 1'b0;
        next_fire = 0;
        for (int j = 0; j < len; j++) begin
            cu = 1'b0; cd = 1'b0; pu = 1'b0; pd = 1'b0;
            if (j >= 1) begin cu = db_up_m[j-1]; cd = db_dn_m[j-1]; end
            if (j >= 2) begin pu = db_up_m[j-2]; pd = db_dn_m[j-2]; end
            case (mode)
                0: begin
                    if (cu && cd) begin
                        mode = 2;
                    end else if ((cu && !pu) || (cd && !pd)) begin
                        dir = cu && !pu;
                        exp_q.push_back({dir, 31'(base + 32'(j) + 32'd1)});
                        next_fire = j + RD;
                        mode = 1;
                    end
                end
                1: begin
                    act = dir ? cu : cd;
                    opp = dir ? cd : cu;
                    if (!act) begin
                        mode = 0;
                    end else if (opp) begin
                        mode = 2;
                    end else if (AUTO && j == next_fire) begin
                        exp_q.push_back({dir, 31'(base + 32'(j) + 32'd1)});
                        next_fire = j + RP;
                    end
                end
                default: begin
                    if (!cu && !cd) mode = 0;
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_segment(input int len, input bit use_model, input int rst_at, input int rst_len);
        logic [31:0] base;
        int rel;
        bit up;
        @(negedge clock);
        reset = 1'b1;
        btn_up = 1'b0;
        btn_down = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_incr", {31'd0, incr_duty}, 32'd0);
        check("reset_decr", {31'd0, decr_duty}, 32'd0);
        reset = 1'b0;
        base = edge_cnt + 32'd1;
        if (use_model) begin
            model_push(len, base);
        end else begin
            while (dexp_rel.size() > 0) begin
                rel = dexp_rel.pop_front();
                up  = dexp_up.pop_front();
                exp_q.push_back({up, 31'(base + 32'(rel))});
            end
        end
        for (int k = 0; k < len; k++) begin
            if (rst_len > 0 && k == rst_at + 2)
                check("midreset_low", {30'd0, incr_duty, decr_duty}, 32'd0);
            btn_up   = raw_up[k];
            btn_down = raw_dn[k];
            reset    = (rst_len > 0) && (k >= rst_at) && (k < rst_at + rst_len);
            @(negedge clock);
        end
    endtask

    task automatic gen_random(input int len);
        int start, bounce, hold, k;
        clear_raw(len);
        for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 3) != 0) begin
                start  = int'($urandom_range(0, 150));
                bounce = int'($urandom_range(0, 25));
                hold   = int'($urandom_range(5, 220));
                k = start;
                for (int i = 0; i < bounce; i++) begin set_raw(b == 0, k, 1'($urandom_range(0, 1))); k++; end
                for (int i = 0; i < hold; i++)   begin set_raw(b == 0, k, 1'b1); k++; end
                for (int i = 0; i < bounce; i++) begin set_raw(b == 0, k, 1'($urandom_range(0, 1))); k++; end
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit prev_i, prev_d, trunc;
        int width;
        logic [31:0] e;
        prev_i = 1'b0; prev_d = 1'b0; trunc = 1'b0; width = 0;
        forever begin
            @(negedge clock);
            if (incr_duty || decr_duty)
                check("exclusive", {31'd0, incr_duty & decr_duty}, 32'd0);
            if ((incr_duty && !prev_i) || (decr_duty && !prev_d)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pulse: got incr=%0b decr=%0b at edge %0d, expected none",
                             incr_duty, decr_duty, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_dir_edge", {incr_duty, edge_cnt[30:0]}, e);
                end
            end
            if (reset && (incr_duty || decr_duty || prev_i || prev_d)) trunc = 1'b1;
            if (incr_duty || decr_duty) width++;
            if ((!incr_duty && prev_i) || (!decr_duty && prev_d)) begin
                if (!trunc) check("pulse_width", 32'(width), 32'(PC));
                width = 0;
                trunc = 1'b0;
            end
            prev_i = incr_duty;
            prev_d = decr_duty;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin : main
        // Idle after reset: no pulses at all.
        clear_raw(200);
        run_segment(200, 1'b0, 0, 0);

        // Clean 20-cycle press.
        clear_raw(120);
        set_range(1'b1, 0, 19);
        push_dexp(1'b1, 19);
        run_segment(120, 1'b0, 0, 0);

        // Bouncing input then a steady press from cycle 40.
        clear_raw(160);
        for (int k = 0; k < 40; k++) raw_up[k] = ((k / 5) % 2) == 0;
        set_range(1'b1, 40, 99);
        push_dexp(1'b1, 59);
        run_segment(160, 1'b0, 0, 0);

        // Long down hold: auto-repeat train or a single pulse.
        clear_raw(300);
        set_range(1'b0, 0, 179);
        push_dexp(1'b0, 19);
        if (AUTO) for (int r = 83; r <= 195; r += RP) push_dexp(1'b0, r);
        run_segment(300, 1'b0, 0, 0);

        // Opposite button locks out; a fresh press after full release fires again.
        clear_raw(340);
        set_range(1'b1, 0, 149);
        set_range(1'b0, 40, 149);
        set_range(1'b1, 250, 279);
        push_dexp(1'b1, 19);
        push_dexp(1'b1, 269);
        run_segment(340, 1'b0, 0, 0);

        // Reset in the middle of a pulse while the button stays held.
        clear_raw(150);
        set_range(1'b1, 0, 59);
        push_dexp(1'b1, 19);
        push_dexp(1'b1, 24 + DB + 3);
        run_segment(150, 1'b0, 21, 3);

        // Randomized bouncing presses on one or both buttons.
        for (int s = 0; s < 14; s++) begin
            gen_random(500);
            run_segment(500, 1'b1, 0, 0);
        end

        repeat (40) @(negedge clock);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        while (exp_q.size() > 0) begin
            $display("FAIL missing_pulse: got nothing, expected dir_up=%0b at edge %0d",
                     exp_q[0][31], exp_q[0][30:0]);
            void'(exp_q.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
